adder_seq_nbit: RTL and testbench
=================================

Name: adder_seq_nbit

Overview:
Parametrised multi-cycle add/subtract unit for WIDTH-bit operands. It processes CHUNK bits per clock, LSB chunk first, through a ripple chain of CHUNK adder_1bit slices, with the carry held in a register between chunks. Start/busy/done handshake, held results, carry-out and signed overflow. Used where a full-width combinational ripple chain is too long for the target clock.

Parameters:
WIDTH, 16, operand and result width in bits
CHUNK, 4, bits processed per cycle; must divide WIDTH; N = WIDTH/CHUNK cycles per operation

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = A+B+Cin, 1 = A-B (Cin ignored)
A  input  WIDTH  operand A, sampled with start
B  input  WIDTH  operand B, sampled with start
Cin  input  1  carry-in for add mode, sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse: results valid
Sum  output  WIDTH  result
Cout  output  1  carry-out; in sub mode 1 = no borrow
Ovf  output  1  two's-complement overflow

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0; internal operand, carry and chunk-counter registers cleared. Reset overrides all other inputs, including mid-operation; a partial result is discarded and never appears on Sum.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch A. Latch B, or ~B when sub=1. Initialise carry to Cin, or to 1 when sub=1. Counter=0. Go to RUN; busy=1 from the next cycle.
- RUN: each cycle adds chunk[counter] of the latched A and B plus the carry register through CHUNK adder_1bit slices. The chunk sum is written into the result shift register and the chunk carry-out into the carry register. Counter increments. After the chunk with counter=N-1, go to DONE.
- busy=1 for exactly N cycles. done=1 for exactly 1 cycle, in the cycle after the last RUN cycle.
- Sum, Cout and Ovf update only on the edge that enters DONE. They hold until the next operation completes or reset. They are stable while busy=1.
- Cout = carry out of bit WIDTH-1.
- Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. The carry into the MSB is captured inside the last chunk.
- start while busy=1 is ignored; operand inputs are don't-care during RUN.
- DONE, start=1: accepted as from IDLE, going straight to RUN (back-to-back operation; done still pulses for its one cycle).
- DONE, start=0: go to IDLE.
- CHUNK=WIDTH is legal: N=1, busy for 1 cycle, done in the following cycle.
- An illegal parameterisation (WIDTH % CHUNK != 0) must fail elaboration.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=16, CHUNK=4, sub=0, A=0x1234, B=0x0FFF, Cin=0, 1-cycle start -> busy high 4 cycles; then done 1 cycle with Sum=0x2233, Cout=0, Ovf=0.
- Add boundaries: 0xFFFF+0x0001 (Cin=0) -> Sum=0x0000, Cout=1, Ovf=0. 0x7FFF+0x0001 -> Sum=0x8000, Cout=0, Ovf=1. 0xFFFF+0x0000 with Cin=1 -> Sum=0x0000, Cout=1.
- Subtract: 0x0005-0x0007 -> Sum=0xFFFE, Cout=0, Ovf=0. 0x8000-0x0001 -> Sum=0x7FFF, Cout=1, Ovf=1. Cin=1 in sub mode has no effect.
- Protocol: start re-pulsed with new operands during RUN -> ignored, first result unchanged. start asserted in the DONE cycle -> second operation runs back-to-back, and its result appears 4 busy cycles later with its own 1-cycle done pulse.
- Reset mid-operation: rst=1 at the 2nd RUN cycle -> next cycle busy=0, done=0, Sum=0, Cout=0, Ovf=0. A following operation completes correctly with no residual carry.
- Parameter sweep: (WIDTH,CHUNK) = (8,1), (8,8), (32,8), random operands vs reference model -> correct Sum/Cout/Ovf, with busy length of 8, 1 and 4 cycles respectively.

Source files
------------

// File: rtl/adder_seq_nbit.sv
// adder_seq_nbit: multi-cycle add/subtract unit for WIDTH-bit operands.
// Each RUN cycle adds CHUNK bits, LSB chunk first, through a ripple chain of
// CHUNK adder_1bit slices. The carry is held in a register between chunks, so
// the critical path is CHUNK full-adder stages, not WIDTH.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   start      operation request, accepted only when busy=0 (IDLE or DONE)
//   sub        0: A+B+Cin, 1: A-B (Cin ignored)
//   A, B       operands, sampled together with start
//   Cin        add-mode carry-in, sampled together with start
//   busy       operation in progress (exactly N = WIDTH/CHUNK cycles)
//   done       one-cycle pulse; Sum/Cout/Ovf are valid from this cycle on
//   Sum        result, held until the next operation completes or reset
//   Cout       carry out of bit WIDTH-1 (sub mode: 1 = no borrow)
//   Ovf        two's-complement overflow
//   dbg_state  current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a request qualified by busy=0. When start=1 is seen at a
// rising edge in IDLE or DONE, A/B/sub/Cin are captured on that edge and busy
// rises in the next cycle. start while busy=1 is ignored. done pulses for one
// cycle after the last RUN cycle; start in that cycle begins a new operation
// immediately. All outputs come straight from flops.
module adder_seq_nbit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       dbg_state
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Refuse to build a unit whose chunks do not tile the operand exactly.
  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("adder_seq_nbit: CHUNK must be >= 1 and divide WIDTH");
  end

  // One full-adder slice: returns {carry_out, sum}.
  function automatic logic [1:0] adder_1bit(input logic a, input logic b,
                                            input logic ci);
    adder_1bit = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;        // shifts right one chunk per RUN cycle
  logic [WIDTH-1:0] b_q, b_d;        // holds B or ~B, shifts like a_q
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;    // result shift register, fills from MSB
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Ripple chain across the low CHUNK bits of the operand shift registers.
  logic [CHUNK:0]       chain;
  logic [CHUNK-1:0]     chunk_sum;
  logic [WIDTH+CHUNK-1:0] res_ext;
  logic [WIDTH-1:0]     res_shift;

  always_comb begin
    logic [1:0] fa;
    chain     = '0;
    chunk_sum = '0;
    chain[0]  = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      fa           = adder_1bit(a_q[i], b_q[i], chain[i]);
      chunk_sum[i] = fa[0];
      chain[i+1]   = fa[1];
    end
  end

  // Chunk results enter at the top and move down, so after N chunks the
  // first (LSB) chunk sits at bit 0. Works for CHUNK == WIDTH as well.
  assign res_ext   = {chunk_sum, res_q};
  assign res_shift = res_ext[WIDTH+CHUNK-1:CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          // Subtraction as A + ~B + 1.
          b_d     = sub ? ~B : B;
          carry_d = sub ? 1'b1 : Cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = res_shift;
        carry_d = chain[CHUNK];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          sum_d   = res_shift;
          cout_d  = chain[CHUNK];
          // In the last chunk, chain[CHUNK-1] is the carry into the MSB.
          ovf_d   = chain[CHUNK] ^ chain[CHUNK-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Testbench for adder_seq_nbit: directed and random operations on a 16/4
// instance, plus a parameter sweep over (8,1), (8,8) and (32,8) instances,
// all checked against an arithmetic reference model.
module tb_adder_seq_nbit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- 16/4 instance ----------------
  logic        start16, sub16, cin16;
  logic [15:0] a16, b16;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;
  logic [1:0]  st16;

  adder_seq_nbit #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .A(a16), .B(b16),
    .Cin(cin16), .busy(busy16), .done(done16), .Sum(sum16), .Cout(cout16),
    .Ovf(ovf16), .dbg_state(st16)
  );

  // ---------------- sweep instances (shared inputs) ----------------
  logic        start_s, sub_s, cin_s;
  logic [31:0] a_s, b_s;

  logic       busy_p, done_p, cout_p, ovf_p;
  logic [7:0] sum_p;
  logic [1:0] st_p;
  adder_seq_nbit #(.WIDTH(8), .CHUNK(1)) u_dut8x1 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub_s), .A(a_s[7:0]),
    .B(b_s[7:0]), .Cin(cin_s), .busy(busy_p), .done(done_p), .Sum(sum_p),
    .Cout(cout_p), .Ovf(ovf_p), .dbg_state(st_p)
  );

  logic       busy_q, done_q, cout_q, ovf_q;
  logic [7:0] sum_q;
  logic [1:0] st_q;
  adder_seq_nbit #(.WIDTH(8), .CHUNK(8)) u_dut8x8 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub_s), .A(a_s[7:0]),
    .B(b_s[7:0]), .Cin(cin_s), .busy(busy_q), .done(done_q), .Sum(sum_q),
    .Cout(cout_q), .Ovf(ovf_q), .dbg_state(st_q)
  );

  logic        busy_w, done_w, cout_w, ovf_w;
  logic [31:0] sum_w;
  logic [1:0]  st_w;
  adder_seq_nbit #(.WIDTH(32), .CHUNK(8)) u_dut32x8 (
    .clk(clk), .rst(rst), .start(start_s), .sub(sub_s), .A(a_s),
    .B(b_s), .Cin(cin_s), .busy(busy_w), .done(done_w), .Sum(sum_w),
    .Cout(cout_w), .Ovf(ovf_w), .dbg_state(st_w)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] last_sum16;   // result the 16-bit DUT must currently hold

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on w-bit values.
  task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic c, output logic [31:0] sum,
                           output logic co, output logic ov);
    longint unsigned m, ua, ub, t;
    longint sa, sb, r, hi, lo;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    sa = longint'(ua) - (ua[w-1] ? longint'(64'd1 << w) : 64'sd0);
    sb = longint'(ub) - (ub[w-1] ? longint'(64'd1 << w) : 64'sd0);
    hi = longint'((64'd1 << (w - 1)) - 64'd1);
    lo = -hi - 64'sd1;
    if (!s) begin
      t  = ua + ub + {63'd0, c};
      co = t[w];
      r  = sa + sb + longint'({63'd0, c});
    end else begin
      t  = ua - ub;
      co = (ua >= ub);
      r  = sa - sb;
    end
    sum = 32'(t & m);
    ov  = (r > hi) || (r < lo);
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns at the falling edge of the
  // done cycle so a caller can issue a back-to-back start right away.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic c, input logic [15:0] es, input logic eco,
                       input logic eov, input bit repulse);
    int cnt;
    cnt = 0;
    start16 = 1'b1; a16 = a; b16 = b; sub16 = s; cin16 = c;
    @(negedge clk);
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
    while (busy16 && cnt < 20) begin
      cnt++;
      check_eq("sum_stable_busy", sum16, last_sum16);
      check_eq("done_low_busy", done16, 0);
      if (repulse && cnt == 1) begin
        start16 = 1'b1; sub16 = ~s;
      end
      if (cnt == 2) start16 = 1'b0;
      @(negedge clk);
    end
    check_eq("busy_len16", cnt, 4);
    check_eq("done16", done16, 1);
    check_eq("sum16", sum16, es);
    check_eq("cout16", cout16, eco);
    check_eq("ovf16", ovf16, eov);
    last_sum16 = es;
  endtask

  task automatic idle16();
    @(negedge clk);
    check_eq("done_pulse_end", done16, 0);
    check_eq("idle_busy", busy16, 0);
    check_eq("idle_state", st16, 0);
  endtask

  task automatic run16_rand();
    logic [31:0] a, b, es;
    logic s, c, eco, eov;
    a = $urandom; b = $urandom;
    s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
    ref_model(16, a, b, s, c, es, eco, eov);
    run16(a[15:0], b[15:0], s, c, es[15:0], eco, eov, 1'b0);
    idle16();
  endtask

  task automatic sweep_one();
    logic [31:0] a, b, e8, e32, rw;
    logic s, c, co8, ov8, co32, ov32;
    logic [7:0] rp, rq;
    logic cp, op, cq, oq, cw, ow;
    int bp, bq, bw;
    bit dp, dq, dw;
    bp = 0; bq = 0; bw = 0; dp = 0; dq = 0; dw = 0;
    rp = '0; rq = '0; rw = '0; cp = 0; op = 0; cq = 0; oq = 0; cw = 0; ow = 0;
    a = $urandom; b = $urandom;
    s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
    ref_model(8, a, b, s, c, e8, co8, ov8);
    ref_model(32, a, b, s, c, e32, co32, ov32);
    start_s = 1'b1; a_s = a; b_s = b; sub_s = s; cin_s = c;
    @(negedge clk);
    start_s = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (busy_p) bp++;
      if (busy_q) bq++;
      if (busy_w) bw++;
      if (done_p && !dp) begin dp = 1; rp = sum_p; cp = cout_p; op = ovf_p; end
      if (done_q && !dq) begin dq = 1; rq = sum_q; cq = cout_q; oq = ovf_q; end
      if (done_w && !dw) begin dw = 1; rw = sum_w; cw = cout_w; ow = ovf_w; end
      @(negedge clk);
    end
    check_eq("busy_len_8x1", bp, 8);
    check_eq("done_8x1", dp, 1);
    check_eq("sum_8x1", rp, e8[7:0]);
    check_eq("cout_8x1", cp, co8);
    check_eq("ovf_8x1", op, ov8);
    check_eq("busy_len_8x8", bq, 1);
    check_eq("done_8x8", dq, 1);
    check_eq("sum_8x8", rq, e8[7:0]);
    check_eq("cout_8x8", cq, co8);
    check_eq("ovf_8x8", oq, ov8);
    check_eq("busy_len_32x8", bw, 4);
    check_eq("done_32x8", dw, 1);
    check_eq("sum_32x8", rw, e32);
    check_eq("cout_32x8", cw, co32);
    check_eq("ovf_32x8", ow, ov32);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start16 = 0; sub16 = 0; cin16 = 0; a16 = '0; b16 = '0;
    start_s = 0; sub_s = 0; cin_s = 0; a_s = '0; b_s = '0;
    last_sum16 = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy16, 0);
    check_eq("rst_done", done16, 0);
    check_eq("rst_sum", sum16, 0);
    check_eq("rst_cout", cout16, 0);
    check_eq("rst_ovf", ovf16, 0);
    check_eq("rst_state", st16, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed adds and subtracts.
    run16(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0); idle16();
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); idle16();
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0); idle16();
    run16(16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0); idle16();
    run16(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0); idle16();
    run16(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0); idle16();
    run16(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0); idle16();

    // start re-pulsed with different operands during RUN is ignored.
    run16(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1); idle16();

    // Back-to-back: second start issued in the DONE cycle.
    run16(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0);
    run16(16'hF000, 16'h1000, 1'b1, 1'b0, 16'hE000, 1'b1, 1'b0, 1'b0); idle16();

    // Reset during the second RUN cycle discards the partial result.
    start16 = 1'b1; a16 = 16'hFFFF; b16 = 16'hFFFF; sub16 = 1'b0; cin16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_busy", busy16, 0);
    check_eq("midrst_done", done16, 0);
    check_eq("midrst_sum", sum16, 0);
    check_eq("midrst_cout", cout16, 0);
    check_eq("midrst_ovf", ovf16, 0);
    last_sum16 = '0;
    run16(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0); idle16();

    // Random operations on the 16/4 instance.
    for (int i = 0; i < 10; i++) run16_rand();

    // Parameter sweep.
    for (int i = 0; i < 8; i++) sweep_one();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case the sequence above wedges.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
